// File: rtl/axi4_lite_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_if
// Purpose  : AXI4-Lite bus bundle with manager/subordinate views.
// Revision : 1.0  initial release
// ============================================================================
interface axi4_lite_if #(
  parameter int C_S_AXI_ADDR_WIDTH = 14,
  parameter int C_S_AXI_DATA_WIDTH = 32
);
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                          S_AXI_AWVALID;
  logic                          S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [3:0]                    S_AXI_WSTRB;
  logic                          S_AXI_WVALID;
  logic                          S_AXI_WREADY;
  logic [1:0]                    S_AXI_BRESP;
  logic                          S_AXI_BVALID;
  logic                          S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                          S_AXI_ARVALID;
  logic                          S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]                    S_AXI_RRESP;
  logic                          S_AXI_RVALID;
  logic                          S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_filter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_filter
// Purpose  : AXI4-Lite subordinate wrapping a programmable Q15 direct-form FIR.
// Revision : 1.0  initial release
// ============================================================================
module axi4_lite_filter #(
  parameter int C_S_AXI_ADDR_WIDTH = 14,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int MAX_TAPS           = 64
) (
  input  wire logic  S_AXI_ACLK,
  input  wire logic  S_AXI_ARESETN,
  axi4_lite_if.slave s_axi
);

  localparam int          c_DW          = C_S_AXI_DATA_WIDTH;
  localparam int          c_IW          = $clog2(MAX_TAPS);
  localparam int          c_SW          = (c_IW + 1 > 8) ? c_IW + 1 : 8;
  localparam logic [31:0] c_X_END       = 32'(4 * MAX_TAPS);
  localparam logic [31:0] c_H_BASE      = 32'h0000_0800;
  localparam logic [31:0] c_H_END       = c_H_BASE + c_X_END;
  localparam logic [31:0] c_RESULT_ADDR = 32'h0000_1000;
  localparam logic [31:0] c_DONE_ADDR   = 32'h0000_1004;
  localparam logic [31:0] c_SIZE_ADDR   = 32'h0000_1008;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Select bits: [0] input RAM, [1] impulse RAM, [2] result, [3] done, [4] size
  function automatic logic [4:0] f_decode(input logic [31:0] a);
    logic [31:0] wd;
    wd          = {a[31:2], 2'b00};
    f_decode    = '0;
    f_decode[0] = (a < c_X_END);
    f_decode[1] = (a >= c_H_BASE) && (a < c_H_END);
    f_decode[2] = (wd == c_RESULT_ADDR);
    f_decode[3] = (wd == c_DONE_ADDR);
    f_decode[4] = (wd == c_SIZE_ADDR);
  endfunction

  function automatic logic [c_DW-1:0] f_sext(input logic [15:0] v);
    f_sext = {{(c_DW-16){v[15]}}, v};
  endfunction

  logic                   r_awready;
  logic                   r_bvalid;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [c_DW-1:0]        r_rdata;
  logic [c_SW-1:0]        r_size;
  logic signed [15:0]     r_x [MAX_TAPS];
  logic signed [15:0]     r_h [MAX_TAPS];
  state_t                 r_state;
  logic [c_IW-1:0]        r_p;
  logic [c_SW-1:0]        r_m;
  logic signed [39:0]     r_acc;
  logic signed [15:0]     r_result;
  logic                   r_done;

  logic [31:0]            w_aw32;
  logic [31:0]            w_ar32;
  logic [4:0]             w_aw_sel;
  logic [4:0]             w_ar_sel;
  logic [c_IW-1:0]        w_aw_idx;
  logic [c_IW-1:0]        w_ar_idx;
  logic                   w_x_wr;
  logic                   w_h_wr;
  logic                   w_size_wr;
  logic [c_DW-1:0]        w_rd_data;
  logic [c_SW-1:0]        w_p_ext;
  logic [c_SW-1:0]        w_idx_full;
  logic signed [15:0]     w_mac_x;
  logic signed [15:0]     w_mac_h;
  logic signed [31:0]     w_prod;
  logic signed [39:0]     w_shift;
  logic signed [15:0]     w_sat;
  logic                   w_unused;

  assign w_aw32    = 32'(s_axi.S_AXI_AWADDR);
  assign w_ar32    = 32'(s_axi.S_AXI_ARADDR);
  assign w_aw_sel  = f_decode(w_aw32);
  assign w_ar_sel  = f_decode(w_ar32);
  assign w_aw_idx  = w_aw32[c_IW+1:2];
  assign w_ar_idx  = w_ar32[c_IW+1:2];

  // AWREADY high marks the single cycle on whose closing edge the write lands
  assign w_x_wr    = r_awready && w_aw_sel[0];
  assign w_h_wr    = r_awready && w_aw_sel[1];
  assign w_size_wr = r_awready && w_aw_sel[4];

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_awready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_size    <= '0;
    end else begin
      r_awready <= 1'b0;
      if (s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !r_bvalid && !r_awready)
        r_awready <= 1'b1;
      if (r_awready)
        r_bvalid <= 1'b1;
      else if (s_axi.S_AXI_BREADY)
        r_bvalid <= 1'b0;
      if (w_size_wr)
        r_size <= (s_axi.S_AXI_WDATA > c_DW'(MAX_TAPS)) ? c_SW'(MAX_TAPS)
                                                        : s_axi.S_AXI_WDATA[c_SW-1:0];
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_x_wr)
      r_x[w_aw_idx] <= s_axi.S_AXI_WDATA[15:0];
    if (w_h_wr)
      r_h[w_aw_idx] <= s_axi.S_AXI_WDATA[15:0];
  end

  always_comb begin
    w_rd_data = '0;
    if (w_ar_sel[0])
      w_rd_data = f_sext(r_x[w_ar_idx]);
    else if (w_ar_sel[1])
      w_rd_data = f_sext(r_h[w_ar_idx]);
    else if (w_ar_sel[2])
      w_rd_data = f_sext(r_result);
    else if (w_ar_sel[3])
      w_rd_data = c_DW'(r_done);
    else if (w_ar_sel[4])
      w_rd_data = c_DW'(r_size);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= 1'b0;
      if (s_axi.S_AXI_ARVALID && !r_rvalid && !r_arready)
        r_arready <= 1'b1;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (s_axi.S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Circular input index (p - m) mod N; p may exceed N if the host wrote past it
  assign w_p_ext    = c_SW'(r_p);
  assign w_idx_full = (w_p_ext >= r_m) ? (w_p_ext - r_m) : (w_p_ext + r_size - r_m);
  assign w_mac_x    = r_x[w_idx_full[c_IW-1:0]];
  assign w_mac_h    = r_h[r_m[c_IW-1:0]];
  assign w_prod     = w_mac_h * w_mac_x;
  assign w_shift    = r_acc >>> 15;

  always_comb begin
    w_sat = w_shift[15:0];
    if (w_shift > 40'sd32767)
      w_sat = 16'sh7FFF;
    else if (w_shift < -40'sd32768)
      w_sat = 16'sh8000;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= S_IDLE;
      r_p      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_done   <= 1'b1;
    end else if (w_x_wr) begin
      r_p     <= w_aw_idx;
      r_m     <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_state <= S_MAC;
    end else begin
      case (r_state)
        S_MAC: begin
          // Size is re-read every iteration so a mid-run resize ends the loop early
          if (r_m >= r_size) begin
            r_state <= S_DONE;
          end else begin
            r_acc <= r_acc + {{8{w_prod[31]}}, w_prod};
            r_m   <= r_m + c_SW'(1);
          end
        end
        S_DONE: begin
          r_result <= w_sat;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_unused = &{1'b0, s_axi.S_AXI_WSTRB, w_idx_full[c_SW-1:c_IW]};

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_filter
// Purpose  : Directed, table-driven self-checking bench for axi4_lite_filter.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi4_lite_filter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axi4_lite_if #(.C_S_AXI_ADDR_WIDTH(14), .C_S_AXI_DATA_WIDTH(32)) bus ();

  axi4_lite_filter #(
    .C_S_AXI_ADDR_WIDTH(14),
    .C_S_AXI_DATA_WIDTH(32),
    .MAX_TAPS(64)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi        (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input bit wr, input logic [13:0] a,
                                  input logic [31:0] d, input logic [31:0] e,
                                  input string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [13:0] a, input logic [31:0] d, input int stall);
    int t;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus.S_AXI_AWREADY && t < 20);
    chk("awready", 32'(bus.S_AXI_AWREADY), 32'd1);
    chk("wready", 32'(bus.S_AXI_WREADY), 32'd1);
    @(posedge clk); #1;
    if (stall == 0) begin
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
    end
    chk("aw_pulse", 32'(bus.S_AXI_AWREADY), 32'd0);
    chk("bvalid", 32'(bus.S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("bvalid_hold", 32'(bus.S_AXI_BVALID), 32'd1);
      chk("aw_no_repulse", 32'(bus.S_AXI_AWREADY), 32'd0);
    end
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_BREADY  = 1'b0;
    chk("bvalid_clear", 32'(bus.S_AXI_BVALID), 32'd0);
  endtask

  task automatic axi_read(input logic [13:0] a, input int stall, output logic [31:0] q);
    int t;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!bus.S_AXI_ARREADY && t < 20);
    chk("arready", 32'(bus.S_AXI_ARREADY), 32'd1);
    @(posedge clk); #1;
    if (stall == 0) bus.S_AXI_ARVALID = 1'b0;
    chk("ar_pulse", 32'(bus.S_AXI_ARREADY), 32'd0);
    chk("rvalid", 32'(bus.S_AXI_RVALID), 32'd1);
    chk("rresp", 32'(bus.S_AXI_RRESP), 32'd0);
    q = bus.S_AXI_RDATA;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("rvalid_hold", 32'(bus.S_AXI_RVALID), 32'd1);
      chk("rdata_hold", bus.S_AXI_RDATA, q);
      chk("ar_no_repulse", 32'(bus.S_AXI_ARREADY), 32'd0);
    end
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY  = 1'b0;
    chk("rvalid_clear", 32'(bus.S_AXI_RVALID), 32'd0);
  endtask

  task automatic read_chk(input string name, input logic [13:0] a, input logic [31:0] e);
    logic [31:0] q;
    axi_read(a, 0, q);
    chk(name, q, e);
  endtask

  task automatic wait_done(input string name);
    logic [31:0] q;
    int polls;
    polls = 0;
    do begin axi_read(14'h1004, 0, q); polls++; end while (q != 32'd1 && polls < 30);
    chk(name, q, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    rst_n = 1'b0;

    add_vec(0, 14'h1004, 32'h0, 32'h0000_0001, "rd_done_rst");
    add_vec(0, 14'h1000, 32'h0, 32'h0000_0000, "rd_result_rst");
    add_vec(0, 14'h1008, 32'h0, 32'h0000_0000, "rd_size_rst");
    add_vec(1, 14'h1008, 32'd61, 32'h0, "");
    add_vec(0, 14'h1008, 32'h0, 32'd61, "rd_size_61");
    add_vec(1, 14'h1008, 32'd200, 32'h0, "");
    add_vec(0, 14'h1008, 32'h0, 32'd64, "rd_size_clamp");
    add_vec(1, 14'h1008, 32'd64, 32'h0, "");
    add_vec(0, 14'h1008, 32'h0, 32'd64, "rd_size_64");
    add_vec(1, 14'h0804, 32'h0001_8000, 32'h0, "");
    add_vec(0, 14'h0804, 32'h0, 32'hFFFF_8000, "rd_h1_sext");
    add_vec(1, 14'h08FC, 32'h0000_7FFF, 32'h0, "");
    add_vec(0, 14'h08FC, 32'h0, 32'h0000_7FFF, "rd_h63");
    add_vec(1, 14'h1000, 32'h0000_1234, 32'h0, "");
    add_vec(0, 14'h1000, 32'h0, 32'h0000_0000, "rd_result_ro");
    add_vec(1, 14'h1004, 32'h0, 32'h0, "");
    add_vec(0, 14'h1004, 32'h0, 32'h0000_0001, "rd_done_ro");
    add_vec(1, 14'h0C00, 32'h5, 32'h0, "");
    add_vec(0, 14'h0C00, 32'h0, 32'h0, "rd_unmapped_c00");
    add_vec(0, 14'h0100, 32'h0, 32'h0, "rd_unmapped_x64");
    add_vec(0, 14'h0900, 32'h0, 32'h0, "rd_unmapped_h64");
    add_vec(0, 14'h100C, 32'h0, 32'h0, "rd_unmapped_100c");

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    chk("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    chk("rst_arready", 32'(bus.S_AXI_ARREADY), 32'd0);
    chk("rst_rvalid", 32'(bus.S_AXI_RVALID), 32'd0);
    chk("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, 0);
      else            read_chk(vecs[i].name, vecs[i].addr, vecs[i].exp);
    end

    // Clear both RAMs so later sums only see intended taps
    for (int i = 0; i < 64; i++) axi_write(14'(14'h0800 + 4 * i), 32'h0, 0);
    for (int i = 0; i < 64; i++) axi_write(14'(4 * i), 32'h0, 0);
    wait_done("done_after_init");
    axi_write(14'h0008, 32'hFFFF_FFFE, 0);
    read_chk("rd_x2_sext", 14'h0008, 32'hFFFF_FFFE);
    wait_done("done_x2");

    // Impulse response
    axi_write(14'h1008, 32'd61, 0);
    axi_write(14'h0800, 32'h0000_7FFF, 0);
    axi_write(14'h0000, 32'd1000, 0);
    wait_done("done_imp1");
    read_chk("result_imp1", 14'h1000, 32'd999);
    axi_write(14'h0004, 32'hFFFF_FE0C, 0);
    wait_done("done_imp2");
    read_chk("result_imp2", 14'h1000, 32'hFFFF_FE0C);

    // Delay tap through the circular wrap
    axi_write(14'h0800, 32'h0, 0);
    axi_write(14'h0804, 32'h0000_4000, 0);
    axi_write(14'h00F0, 32'd2000, 0);
    wait_done("done_wrap_a");
    axi_write(14'h0000, 32'd10, 0);
    wait_done("done_wrap_b");
    read_chk("result_wrap", 14'h1000, 32'd1000);

    // Saturation both ways
    axi_write(14'h1008, 32'd4, 0);
    for (int i = 0; i < 4; i++) axi_write(14'(14'h0800 + 4 * i), 32'h0000_7FFF, 0);
    for (int i = 0; i < 4; i++) axi_write(14'(4 * i), 32'h0000_7FFF, 0);
    wait_done("done_sat_pos");
    read_chk("result_sat_pos", 14'h1000, 32'h0000_7FFF);
    for (int i = 0; i < 4; i++) axi_write(14'(4 * i), 32'hFFFF_8000, 0);
    wait_done("done_sat_neg");
    read_chk("result_sat_neg", 14'h1000, 32'hFFFF_8000);

    // Back-pressure on both response channels
    axi_write(14'h1008, 32'd61, 5);
    axi_read(14'h1008, 5, q);
    chk("rd_size_stall", q, 32'd61);

    // Input write during MAC restarts the sum with the new p
    for (int i = 1; i < 4; i++) axi_write(14'(14'h0800 + 4 * i), 32'h0, 0);
    axi_write(14'h0014, 32'd100, 0);
    read_chk("result_during_mac", 14'h1000, 32'hFFFF_8000);
    read_chk("done_during_mac", 14'h1004, 32'd0);
    axi_write(14'h0018, 32'd200, 0);
    read_chk("done_after_restart", 14'h1004, 32'd0);
    wait_done("done_restart");
    read_chk("result_restart", 14'h1000, 32'd199);

    // Zero taps completes at once with a zero result
    axi_write(14'h1008, 32'd0, 0);
    axi_write(14'h0000, 32'd5, 0);
    read_chk("done_n0", 14'h1004, 32'd1);
    read_chk("result_n0", 14'h1000, 32'd0);

    // Asynchronous reset with a write response pending and MAC running
    axi_write(14'h1008, 32'd61, 0);
    bus.S_AXI_AWADDR = 14'h0000; bus.S_AXI_WDATA = 32'd1000;
    bus.S_AXI_AWVALID = 1'b1;    bus.S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.S_AXI_AWVALID = 1'b0;    bus.S_AXI_WVALID = 1'b0;
    chk("bvalid_before_rst", 32'(bus.S_AXI_BVALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    chk("async_rst_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    read_chk("done_after_rst", 14'h1004, 32'd1);
    read_chk("result_after_rst", 14'h1000, 32'd0);
    read_chk("size_after_rst", 14'h1008, 32'd0);
    read_chk("h0_kept_after_rst", 14'h0800, 32'h0000_7FFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi4_lite_filter.md
Name: axi4_lite_filter

Overview:
AXI4-Lite subordinate implementing a programmable FIR filter (direct convolution) for a host-side AXI4-Lite manager.
- Host loads the tap count and up to MAX_TAPS 16-bit signed coefficients into the impulse RAM.
- Host then writes input samples into a circular input RAM; each sample write starts one convolution.
- Host polls a done flag and reads the 16-bit signed result.

Parameters:
- C_S_AXI_ADDR_WIDTH, 14, byte address width. Bits above those decoded are ignored.
- C_S_AXI_DATA_WIDTH, 32, data width.
- MAX_TAPS, 64, depth of the input and impulse RAMs; maximum tap count.

Ports:
- S_AXI_ACLK  in  1  single clock; all logic on rising edge.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  write-address handshake.
- S_AXI_WDATA  in  DATA_WIDTH  write data.
- S_AXI_WSTRB  in  4  byte strobes; ignored, full word always written.
- S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  write-data handshake.
- S_AXI_BRESP  out  2 / S_AXI_BVALID  out  1 / S_AXI_BREADY  in  1  write response.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1 / S_AXI_ARREADY  out  1  read-address handshake.
- S_AXI_RDATA  out  DATA_WIDTH / S_AXI_RRESP  out  2 / S_AXI_RVALID  out  1 / S_AXI_RREADY  in  1  read data.

Behaviour:
- Reset (async, ARESETN=0):
  - Outputs: all READY/VALID low, RDATA=0, BRESP=RRESP=0.
  - Internal: size=0, result=0, done=1, busy=0, last-written input index p=0.
  - RAM contents are not reset.
- Address map (byte address; word index = addr[..:2]):
  - 0x0000+4k, k<MAX_TAPS: input RAM x[k]. R/W; stores WDATA[15:0] signed.
  - 0x0800+4i, i<MAX_TAPS: impulse RAM h[i]. R/W; stores WDATA[15:0] signed.
  - 0x1000: result. RO; 16-bit signed, sign-extended to 32 bits.
  - 0x1004: done flag. RO; bit0 = done, other bits 0.
  - 0x1008: size N. R/W; WDATA clamped to MAX_TAPS, stored in 8 bits minimum.
  - RAM reads return the stored value sign-extended.
  - Unmapped addresses and writes to RO registers: writes ignored, reads return 0.
  - BRESP/RRESP are always 00 (OKAY).
- Write channel:
  - When AWVALID & WVALID & !BVALID & !AWREADY, assert AWREADY and WREADY together for exactly one cycle; the write is performed on that edge.
  - BVALID rises the next cycle and holds until BREADY.
  - No new write is accepted while BVALID is high.
- Read channel:
  - When ARVALID & !RVALID & !ARREADY, assert ARREADY for one cycle.
  - RVALID and RDATA are registered the next cycle and held stable until RREADY.
  - Read and write channels operate independently.
- Convolution engine, states IDLE -> MAC -> DONE -> IDLE:
  - A write to input RAM index k sets p=k, clears done, clears the accumulator and enters MAC.
  - MAC performs one multiply-accumulate per cycle for m=0..N-1: acc += h[m]*x[(p-m) mod N].
  - Wrap-around: if p<m, the input index is p-m+N.
  - Products are 32-bit signed; the accumulator is 40-bit signed.
  - DONE: result = saturate16(acc >>> 15), i.e. coefficients are Q15. Set done=1 and return to IDLE.
  - Latency: done is set no later than N+3 cycles after the write handshake.
  - N=0: done is set within 2 cycles, result=0.
- Simultaneous and boundary events:
  - An input write during MAC aborts and restarts with the new p.
  - Coefficient or size writes during MAC take effect from the next MAC iteration and do not restart the computation.
  - A read of result during MAC returns the previous result.
  - Reset mid-transaction drops any handshake in flight and returns the block to its reset state.

Test Plan:
- Reset, then read 0x1004 -> RDATA=1. Read 0x1000 -> 0. Read 0x1008 -> 0. Every response RRESP=00.
- Write size 61 to 0x1008, then read it back -> 61. Write 200 -> reads back MAX_TAPS (64). Each write produces exactly one AWREADY/WREADY pulse and one BVALID, held until BREADY.
- Impulse test: N=61, h[0]=0x7FFF, all other h=0; write x[0]=1000 -> poll done=1, result=999 (1000*32767>>15). Write x[1]=-500 -> result=-500 (rounds toward -inf: -16383500>>>15 = -500).
- Delay/wrap test: N=61, h[1]=0x4000, others 0; x[60]=2000, then write x[0]=10 -> result=1000 (h[1]*x[60] selected via the wrap-around index).
- Saturation: N=4, all h=0x7FFF, all x=32767, write x[3] -> result=32767. Repeat with all x=-32768 -> result=-32768.
- Handshake stress: hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and RDATA held stable, no new AWREADY/ARREADY pulse. Issue an input write during MAC -> done stays 0 until the restarted sum completes with the new p.
